// File: rtl/sync_ram_dp_wbe_pipe.sv
// Dual-port byte-enable block RAM with 1- or 2-cycle read latency,
// per-port read-valid strobes and port-0 priority on write collisions.
module sync_ram_dp_wbe_pipe #(
   parameter int    DWIDTH       = 32,
   parameter int    AWIDTH       = 8,
   parameter int    DEPTH        = 1 << AWIDTH,
   parameter int    READ_LATENCY = 1,
   parameter int    WRITE_FIRST  = 0,
   parameter string MIF_HEX      = "",
   parameter string MIF_BIN      = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en0,
   input  logic [DWIDTH/8-1:0]   wbe0,
   input  logic [AWIDTH-1:0]     addr0,
   input  logic [DWIDTH-1:0]     d0,
   output logic [DWIDTH-1:0]     q0,
   output logic                  qv0,
   input  logic                  en1,
   input  logic [DWIDTH/8-1:0]   wbe1,
   input  logic [AWIDTH-1:0]     addr1,
   input  logic [DWIDTH-1:0]     d1,
   output logic [DWIDTH-1:0]     q1,
   output logic                  qv1,
   output logic                  collision
);

   localparam int NB = DWIDTH / 8;

   logic [DWIDTH-1:0] mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++)
         mem[i] = '0;
   end

   logic              acc0, acc1;
   logic [NB-1:0]     wl0, wl1;
   logic              coll;
   logic [DWIDTH-1:0] old0, old1;
   logic [DWIDTH-1:0] mw0, mw1;
   logic [DWIDTH-1:0] rd0, rd1;

   assign acc0 = en0 && !rst;
   assign acc1 = en1 && !rst;
   assign wl0  = {NB{acc0}} & wbe0;
   assign wl1  = {NB{acc1}} & wbe1;
   assign coll = (addr0 == addr1) && (|(wl0 & wl1));
   assign old0 = mem[addr0];
   assign old1 = mem[addr1];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wl1[i])
            mem[addr1][8*i +: 8] <= d1[8*i +: 8];
         if (wl0[i])
            mem[addr0][8*i +: 8] <= d0[8*i +: 8];
      end
   end

   always_comb begin
      mw0 = old0;
      mw1 = old1;
      for (int i = 0; i < NB; i++) begin
         if (wl0[i])
            mw0[8*i +: 8] = d0[8*i +: 8];
         if (wl1[i])
            mw1[8*i +: 8] = d1[8*i +: 8];
         if (coll && wl0[i])
            mw1[8*i +: 8] = d0[8*i +: 8];
      end
   end

   assign rd0 = (WRITE_FIRST != 0) ? mw0 : old0;
   assign rd1 = (WRITE_FIRST != 0) ? mw1 : old1;

   logic [DWIDTH-1:0] s1_q0, s1_q1;
   logic              s1_v0, s1_v1;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q0     <= '0;
         s1_q1     <= '0;
         s1_v0     <= 1'b0;
         s1_v1     <= 1'b0;
         collision <= 1'b0;
      end else begin
         s1_v0     <= en0;
         s1_v1     <= en1;
         collision <= coll;
         if (en0)
            s1_q0 <= rd0;
         if (en1)
            s1_q1 <= rd1;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_oreg
         logic [DWIDTH-1:0] s2_q0, s2_q1;
         logic              s2_v0, s2_v1;

         always_ff @(posedge clk) begin
            if (rst) begin
               s2_q0 <= '0;
               s2_q1 <= '0;
               s2_v0 <= 1'b0;
               s2_v1 <= 1'b0;
            end else begin
               s2_v0 <= s1_v0;
               s2_v1 <= s1_v1;
               if (s1_v0)
                  s2_q0 <= s1_q0;
               if (s1_v1)
                  s2_q1 <= s1_q1;
            end
         end

         assign q0  = s2_q0;
         assign q1  = s2_q1;
         assign qv0 = s2_v0;
         assign qv1 = s2_v1;
      end else begin : g_noreg
         assign q0  = s1_q0;
         assign q1  = s1_q1;
         assign qv0 = s1_v0;
         assign qv1 = s1_v1;
      end
   endgenerate

endmodule
